// File: rtl/risc_v_pkg.sv
// rtl/risc_v_pkg.sv - opcodes, function codes and control enums shared by the single-cycle core
// Contents: RV32I opcode/funct3/funct7 constants, alu_op_t, write-back and next-pc selectors,
//           helpers mapping funct3 to an ALU operation.
package risc_v_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_t;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
   typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR} pc_sel_t;

   // alt selects SUB / SRA; the caller decides when funct7[5] is meaningful.
   function automatic alu_op_t alu_op_decode(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     return ALU_SLL;
         F3_SLT:     return ALU_SLT;
         F3_SLTU:    return ALU_SLTU;
         F3_XOR:     return ALU_XOR;
         F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
         F3_OR:      return ALU_OR;
         default:    return ALU_AND;
      endcase
   endfunction

   // Equality branches use SUB (zero flag); ordered branches use bit 0 of SLT/SLTU.
   function automatic alu_op_t branch_alu_op(input logic [2:0] f3);
      case (f3)
         F3_BEQ, F3_BNE: return ALU_SUB;
         F3_BLT, F3_BGE: return ALU_SLT;
         default:        return ALU_SLTU;
      endcase
   endfunction

endpackage

// File: rtl/risc_v_single_cycle_if.sv
// rtl/risc_v_single_cycle_if.sv - operand/result bundle between the core datapath and its ALU
// Signals: a, b (operands), op (alu_op_t), result (32-bit), zero (result == 0).
// Modports: master drives operands and reads the result; slave is the ALU.
interface risc_v_single_cycle_if;
   import risc_v_pkg::*;

   logic [31:0] a;
   logic [31:0] b;
   alu_op_t     op;
   logic [31:0] result;
   logic        zero;

   modport master (output a, b, op, input result, zero);
   modport slave  (input a, b, op, output result, zero);

endinterface

// File: rtl/risc_v_alu.sv
// rtl/risc_v_alu.sv - combinational 32-bit ALU for the single-cycle core
// Ports: alu (slave modport) - a, b, op in; result, zero out.
module risc_v_alu
   import risc_v_pkg::*;
(
   risc_v_single_cycle_if.slave alu
);

   always_comb begin
      alu.result = 32'd0;
      case (alu.op)
         ALU_ADD:  alu.result = alu.a + alu.b;
         ALU_SUB:  alu.result = alu.a - alu.b;
         ALU_AND:  alu.result = alu.a & alu.b;
         ALU_OR:   alu.result = alu.a | alu.b;
         ALU_XOR:  alu.result = alu.a ^ alu.b;
         ALU_SLL:  alu.result = alu.a << alu.b[4:0];
         ALU_SRL:  alu.result = alu.a >> alu.b[4:0];
         ALU_SRA:  alu.result = $signed(alu.a) >>> alu.b[4:0];
         ALU_SLT:  alu.result = {31'd0, $signed(alu.a) < $signed(alu.b)};
         ALU_SLTU: alu.result = {31'd0, alu.a < alu.b};
         default:  alu.result = 32'd0;
      endcase
   end

   assign alu.zero = (alu.result == 32'd0);

endmodule

// File: rtl/risc_v_single_cycle.sv
// rtl/risc_v_single_cycle.sv - single-cycle RV32I-subset core with internal ROM, register file and RAM
// Ports: clk - rising-edge clock; rst_n - synchronous reset, active HIGH despite the name.
// Observable state: pc, regs[0:31], imem[0:IMEM_DEPTH-1], dmem[0:DMEM_DEPTH-1].
module risc_v_single_cycle
   import risc_v_pkg::*;
#(
   parameter int          IMEM_DEPTH = 256,
   parameter int          DMEM_DEPTH = 256,
   parameter string       IMEM_INIT  = "program.hex",
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input logic clk,
   input logic rst_n
);

   localparam int IA = $clog2(IMEM_DEPTH);
   localparam int DA = $clog2(DMEM_DEPTH);

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic [31:0] dmem [0:DMEM_DEPTH-1];
   logic [31:0] regs [0:31];
   logic [31:0] pc;

   // Memory images are power-up contents.
   initial begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 32'd0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = 32'd0;
   end

   risc_v_single_cycle_if alu_bus ();
   risc_v_alu u_alu (.alu(alu_bus.slave));

   logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, pc_plus4, wb_data, next_pc, load_data;
   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        reg_we, mem_we, r_legal, i_legal, taken;
   wb_sel_t     wb_sel;
   pc_sel_t     pc_sel;
   logic        unused_pc_bits;

   assign instr    = imem[pc[IA+1:2]];
   assign opcode   = instr[6:0];
   assign rd       = instr[11:7];
   assign f3       = instr[14:12];
   assign rs1      = instr[19:15];
   assign rs2      = instr[24:20];
   assign f7       = instr[31:25];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u    = {instr[31:12], 12'd0};
   assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign pc_plus4 = pc + 32'd4;

   assign load_data      = dmem[alu_bus.result[DA+1:2]];
   assign unused_pc_bits = ^{pc[1:0], pc[31:IA+2]};

   // funct7 must be all-zero except SUB/SRA; anything else decodes as a NOP.
   assign r_legal = (f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
   assign i_legal = (f3 == F3_SLL)     ? (f7 == F7_BASE) :
                    (f3 == F3_SRL_SRA) ? ((f7 == F7_BASE) || (f7 == F7_ALT)) : 1'b1;

   // Decode: operand selection and control, nothing downstream of the ALU.
   always_comb begin
      alu_bus.a  = rs1_val;
      alu_bus.b  = rs2_val;
      alu_bus.op = ALU_ADD;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      wb_sel     = WB_ALU;
      pc_sel     = PC_PLUS4;
      case (opcode)
         OP_R: if (r_legal) begin
            alu_bus.op = alu_op_decode(f3, f7[5]);
            reg_we     = 1'b1;
         end
         OP_I: if (i_legal) begin
            alu_bus.b  = imm_i;
            alu_bus.op = alu_op_decode(f3, (f3 == F3_SRL_SRA) && f7[5]);
            reg_we     = 1'b1;
         end
         OP_LOAD: if (f3 == F3_LW) begin
            alu_bus.b = imm_i;
            reg_we    = 1'b1;
            wb_sel    = WB_MEM;
         end
         OP_STORE: if (f3 == F3_SW) begin
            alu_bus.b = imm_s;
            mem_we    = 1'b1;
         end
         OP_BRANCH: if ((f3 != 3'b010) && (f3 != 3'b011)) begin
            alu_bus.op = branch_alu_op(f3);
            pc_sel     = PC_BRANCH;
         end
         OP_JAL: begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_sel = PC_JAL;
         end
         OP_JALR: if (f3 == F3_JALR) begin
            alu_bus.b = imm_i;
            reg_we    = 1'b1;
            wb_sel    = WB_PC4;
            pc_sel    = PC_JALR;
         end
         OP_LUI: begin
            alu_bus.a = 32'd0;
            alu_bus.b = imm_u;
            reg_we    = 1'b1;
         end
         OP_AUIPC: begin
            alu_bus.a = pc;
            alu_bus.b = imm_u;
            reg_we    = 1'b1;
         end
         default: ;
      endcase
   end

   // Post-ALU: branch resolution, write-back mux, next pc.
   always_comb begin
      case (f3)
         F3_BEQ:          taken = alu_bus.zero;
         F3_BNE:          taken = !alu_bus.zero;
         F3_BLT, F3_BLTU: taken = alu_bus.result[0];
         default:         taken = !alu_bus.result[0];
      endcase
      case (wb_sel)
         WB_MEM:  wb_data = load_data;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_bus.result;
      endcase
      case (pc_sel)
         PC_BRANCH: next_pc = taken ? (pc + imm_b) : pc_plus4;
         PC_JAL:    next_pc = pc + imm_j;
         PC_JALR:   next_pc = alu_bus.result & ~32'd1;
         default:   next_pc = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         pc <= next_pc;
         if (reg_we && (rd != 5'd0)) regs[rd] <= wb_data;
      end
   end

   // Kept apart from the register block because dmem also carries power-up contents.
   always @(posedge clk) begin
      if (!rst_n && mem_we) dmem[alu_bus.result[DA+1:2]] <= rs2_val;
   end

endmodule

// File: tb/tb_risc_v_single_cycle.sv
// tb/tb_risc_v_single_cycle.sv - self-checking bench for risc_v_single_cycle
module tb_risc_v_single_cycle;
   import risc_v_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] prog [0:255];
   logic [31:0] exp_regs [0:31];

   always #5 clk = ~clk;

   risc_v_single_cycle #(
      .IMEM_DEPTH(256), .DMEM_DEPTH(256), .IMEM_INIT(""), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n)
   );

   risc_v_single_cycle_if alu_bus ();
   risc_v_alu u_alu_unit (.alu(alu_bus.slave));

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic int rand12();
      return int'($urandom_range(4095)) - 2048;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 32'd0;
      for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
   endtask

   // Loads the ROM under reset, then releases reset so the next edge executes imem[0].
   task automatic start_program();
      rst_n = 1'b1;
      for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
      step(2);
      rst_n = 1'b0;
   endtask

   task automatic test_reset();
      clear_prog();
      for (int i = 0; i < 16; i++)
         prog[i] = enc_i(12'($urandom), 5'd0, 3'b000, 5'($urandom_range(1, 31)), 7'b0010011);
      start_program();
      step(12);
      rst_n = 1'b1;
      step(2);
      checks++;
      if (dut.pc !== 32'h0) begin
         failures++; $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h0);
      end
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (dut.regs[r] !== 32'd0) begin
            failures++; $display("FAIL reset_x%0d: got %h expected %h", r, dut.regs[r], 32'd0);
         end
      end
      rst_n = 1'b0;
      step(1);
      checks++;
      if (dut.pc !== 32'h4) begin
         failures++; $display("FAIL reset_release_pc: got %h expected %h", dut.pc, 32'h4);
      end
   endtask

   task automatic test_alu_unit();
      alu_op_t     ops [0:9] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                                 ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
      logic [31:0] a, b, expv;
      alu_op_t     op;
      for (int n = 0; n < 30; n++) begin
         op = ops[$urandom_range(9)];
         a  = $urandom;
         b  = (n % 5 == 0) ? a : $urandom;
         case (op)
            ALU_ADD:  expv = a + b;
            ALU_SUB:  expv = a - b;
            ALU_AND:  expv = a & b;
            ALU_OR:   expv = a | b;
            ALU_XOR:  expv = a ^ b;
            ALU_SLL:  expv = a << (b % 32);
            ALU_SRL:  expv = a >> (b % 32);
            ALU_SRA:  expv = 32'(int'(a) >>> (b % 32));
            ALU_SLT:  expv = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default:  expv = (a < b) ? 32'd1 : 32'd0;
         endcase
         alu_bus.a  = a;
         alu_bus.b  = b;
         alu_bus.op = op;
         #1;
         checks++;
         if (alu_bus.result !== expv || alu_bus.zero !== (expv == 32'd0)) begin
            failures++;
            $display("FAIL alu_unit %s: got %h/%b expected %h/%b", op.name(), alu_bus.result,
                     alu_bus.zero, expv, expv == 32'd0);
         end
      end
   endtask

   task automatic test_alu_seq(input int v1, input int v2, input int sh);
      logic [31:0] a, b, t1, t2;
      a = v1; b = v2; t1 = v1; t2 = v2;
      clear_prog();
      prog[0]  = enc_i(t1[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011);
      prog[1]  = enc_i(t2[11:0], 5'd0, 3'b000, 5'd2, 7'b0010011);
      prog[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
      prog[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
      prog[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5);
      prog[5]  = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6);
      prog[6]  = enc_i({7'h20, 5'(sh)}, 5'd2, 3'b101, 5'd7, 7'b0010011);
      prog[7]  = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
      prog[8]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd8);
      prog[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd9);
      prog[10] = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd10);
      prog[11] = enc_i(t2[11:0], 5'd1, 3'b110, 5'd11, 7'b0010011);
      prog[12] = enc_i(t2[11:0], 5'd1, 3'b011, 5'd12, 7'b0010011);
      exp_regs[1]  = a;
      exp_regs[2]  = b;
      exp_regs[3]  = a + b;
      exp_regs[4]  = a - b;
      exp_regs[5]  = (v2 < v1) ? 32'd1 : 32'd0;
      exp_regs[6]  = (b < a) ? 32'd1 : 32'd0;
      exp_regs[7]  = 32'(v2 >>> sh);
      exp_regs[8]  = a ^ b;
      exp_regs[9]  = a << (b % 32);
      exp_regs[10] = b >> (a % 32);
      exp_regs[11] = a | b;
      exp_regs[12] = (a < b) ? 32'd1 : 32'd0;
      start_program();
      step(13);
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (dut.regs[r] !== exp_regs[r]) begin
            failures++;
            $display("FAIL alu_seq(%0d,%0d) x%0d: got %h expected %h", v1, v2, r, dut.regs[r], exp_regs[r]);
         end
      end
   endtask

   task automatic test_memory();
      int          roff, ridx, rv;
      logic [31:0] t;
      roff = int'($urandom_range(2047));
      ridx = (roff / 4) % 256;
      rv   = rand12();
      t    = rv;
      clear_prog();
      prog[0] = enc_i(12'h055, 5'd0, 3'b000, 5'd1, 7'b0010011);
      prog[1] = enc_s(12'd8, 5'd1, 5'd0);
      prog[2] = enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'b0000011);
      prog[3] = enc_i(12'd1024, 5'd0, 3'b000, 5'd3, 7'b0010011);
      prog[4] = enc_i(12'd8, 5'd3, 3'b010, 5'd6, 7'b0000011);
      prog[5] = enc_i(t[11:0], 5'd0, 3'b000, 5'd4, 7'b0010011);
      prog[6] = enc_s(12'(roff), 5'd4, 5'd0);
      prog[7] = enc_i(12'(roff), 5'd0, 3'b010, 5'd7, 7'b0000011);
      start_program();
      step(2);
      checks++;
      if (dut.dmem[2] !== 32'h55) begin
         failures++; $display("FAIL mem_sw: got %h expected %h", dut.dmem[2], 32'h55);
      end
      step(1);
      checks++;
      if (dut.regs[2] !== 32'h55) begin
         failures++; $display("FAIL mem_lw: got %h expected %h", dut.regs[2], 32'h55);
      end
      step(2);
      checks++;
      if (dut.regs[6] !== 32'h55) begin
         failures++; $display("FAIL mem_wrap_lw: got %h expected %h", dut.regs[6], 32'h55);
      end
      step(3);
      checks++;
      if (dut.dmem[ridx] !== t) begin
         failures++; $display("FAIL mem_rand_sw off=%0d: got %h expected %h", roff, dut.dmem[ridx], t);
      end
      checks++;
      if (dut.regs[7] !== t) begin
         failures++; $display("FAIL mem_rand_lw off=%0d: got %h expected %h", roff, dut.regs[7], t);
      end
   endtask

   task automatic test_branches(input int v1, input int v2);
      logic [2:0]  f3s [0:5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      logic [31:0] a, b, mpc;
      logic [31:0] exp_pc [0:5];
      int          off;
      logic        tk;
      a = v1; b = v2;
      clear_prog();
      prog[0] = enc_i(a[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011);
      prog[1] = enc_i(b[11:0], 5'd0, 3'b000, 5'd2, 7'b0010011);
      mpc = 32'h8;
      for (int k = 0; k < 6; k++) begin
         off = 4 * int'($urandom_range(2, 4));
         prog[mpc / 4] = enc_b(13'(off), 5'd2, 5'd1, f3s[k]);
         case (k)
            0:       tk = (v1 == v2);
            1:       tk = (v1 != v2);
            2:       tk = (v1 < v2);
            3:       tk = (v1 >= v2);
            4:       tk = (a < b);
            default: tk = (a >= b);
         endcase
         mpc = tk ? mpc + 32'(off) : mpc + 32'd4;
         exp_pc[k] = mpc;
      end
      start_program();
      step(2);
      for (int k = 0; k < 6; k++) begin
         step(1);
         checks++;
         if (dut.pc !== exp_pc[k]) begin
            failures++;
            $display("FAIL branch(%0d,%0d) f3=%b: got %h expected %h", v1, v2, f3s[k], dut.pc, exp_pc[k]);
         end
      end
   endtask

   task automatic test_jumps();
      logic [19:0] u1, u2;
      clear_prog();
      prog[4] = enc_j(21'd8, 5'd1);
      prog[5] = enc_u(20'h12345, 5'd3, 7'b0110111);
      prog[6] = enc_i(12'd3, 5'd1, 3'b000, 5'd0, 7'b1100111);
      start_program();
      step(4);
      checks++;
      if (dut.pc !== 32'h10) begin
         failures++; $display("FAIL nop_run_pc: got %h expected %h", dut.pc, 32'h10);
      end
      step(1);
      checks++;
      if (dut.regs[1] !== 32'h14 || dut.pc !== 32'h18) begin
         failures++; $display("FAIL jal: got x1=%h pc=%h expected x1=14 pc=18", dut.regs[1], dut.pc);
      end
      step(1);
      checks++;
      if (dut.pc !== 32'h16) begin
         failures++; $display("FAIL jalr: got %h expected %h", dut.pc, 32'h16);
      end
      step(1);
      checks++;
      if (dut.regs[3] !== 32'h1234_5000 || dut.pc !== 32'h1a) begin
         failures++; $display("FAIL lui: got x3=%h pc=%h expected x3=12345000 pc=1a", dut.regs[3], dut.pc);
      end
      step(1);
      checks++;
      if (dut.pc !== 32'h16) begin
         failures++; $display("FAIL jalr_again: got %h expected %h", dut.pc, 32'h16);
      end

      u1 = 20'($urandom);
      u2 = 20'($urandom);
      clear_prog();
      prog[8]  = enc_u(20'h1, 5'd4, 7'b0010111);
      prog[9]  = enc_u(u1, 5'd5, 7'b0110111);
      prog[10] = enc_u(u2, 5'd6, 7'b0010111);
      start_program();
      step(9);
      checks++;
      if (dut.regs[4] !== 32'h1020 || dut.pc !== 32'h24) begin
         failures++; $display("FAIL auipc: got x4=%h pc=%h expected x4=1020 pc=24", dut.regs[4], dut.pc);
      end
      step(2);
      checks++;
      if (dut.regs[5] !== 32'(u1) * 32'd4096) begin
         failures++; $display("FAIL lui_rand: got %h expected %h", dut.regs[5], 32'(u1) * 32'd4096);
      end
      checks++;
      if (dut.regs[6] !== 32'h28 + 32'(u2) * 32'd4096) begin
         failures++; $display("FAIL auipc_rand: got %h expected %h", dut.regs[6], 32'h28 + 32'(u2) * 32'd4096);
      end
   endtask

   task automatic test_illegal_reset();
      logic [31:0] t1, t2;
      t1 = rand12();
      do t2 = rand12(); while (t2 == t1);
      clear_prog();
      prog[0] = enc_i(t1[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011);
      prog[1] = enc_i(t2[11:0], 5'd0, 3'b000, 5'd2, 7'b0010011);
      prog[2] = enc_s(12'h40, 5'd1, 5'd0);
      prog[3] = 32'hFFFF_FFFF;
      prog[4] = enc_s(12'h40, 5'd2, 5'd0);
      exp_regs[1] = t1;
      exp_regs[2] = t2;
      start_program();
      step(4);
      checks++;
      if (dut.pc !== 32'h10 || dut.dmem[16] !== t1) begin
         failures++; $display("FAIL illegal_nop: got pc=%h mem=%h expected pc=10 mem=%h", dut.pc, dut.dmem[16], t1);
      end
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (dut.regs[r] !== exp_regs[r]) begin
            failures++; $display("FAIL illegal_x%0d: got %h expected %h", r, dut.regs[r], exp_regs[r]);
         end
      end
      rst_n = 1'b1;
      step(1);
      checks++;
      if (dut.pc !== 32'h0 || dut.dmem[16] !== t1) begin
         failures++; $display("FAIL midreset: got pc=%h mem=%h expected pc=0 mem=%h", dut.pc, dut.dmem[16], t1);
      end
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (dut.regs[r] !== 32'd0) begin
            failures++; $display("FAIL midreset_x%0d: got %h expected %h", r, dut.regs[r], 32'd0);
         end
      end
      rst_n = 1'b0;
   endtask

   initial begin
      step(1);
      test_reset();
      test_alu_unit();
      test_alu_seq(5, -3, 1);
      for (int n = 0; n < 3; n++) test_alu_seq(rand12(), rand12(), int'($urandom_range(31)));
      test_memory();
      test_branches(-1, 1);
      test_branches(7, 7);
      for (int n = 0; n < 3; n++) test_branches(rand12(), rand12());
      test_jumps();
      test_illegal_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
